// File: rtl/axis_complex_combiner.sv
// ---------------------------------------------------------------------------
// axis_complex_combiner
//
// Joins one beat from every enabled real/imag AXI-Stream input pair, sums the
// samples lane by lane (signed), scales each lane sum by an arithmetic right
// shift and emits a packed {imag, real} complex stream. A two-register
// stallable pipeline carries full backpressure.
//
// Optional feature macro: AXIS_COMBINER_SAT_EN
//   defined   : each shifted lane saturates to the SAMPLE_WIDTH signed range
//   undefined : each shifted lane keeps its low SAMPLE_WIDTH bits (wrap)
//
// Ports
//   clock               sole clock
//   resetn              asynchronous active-low reset
//   ch_enable           per-channel include mask, applied at each fire edge
//   s_axis_real_*       NCH real inputs (tdata, tvalid, tlast, tready)
//   s_axis_imag_*       NCH imag inputs (tdata, tvalid, tlast, tready)
//   m_axis_s2mm_*       packed complex output {imag, real}, tkeep, tvalid,
//                       tlast, tready
//   tlast_err           sticky flag: enabled channels disagreed on tlast
// ---------------------------------------------------------------------------
module axis_complex_combiner #(
   parameter int NCH          = 4,
   parameter int SDATA_WIDTH  = 128,
   parameter int SAMPLE_WIDTH = 16,
   parameter int SHIFT        = 2
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic [NCH-1:0]             ch_enable,
   input  logic [NCH*SDATA_WIDTH-1:0] s_axis_real_tdata,
   input  logic [NCH-1:0]             s_axis_real_tvalid,
   input  logic [NCH-1:0]             s_axis_real_tlast,
   output logic [NCH-1:0]             s_axis_real_tready,
   input  logic [NCH*SDATA_WIDTH-1:0] s_axis_imag_tdata,
   input  logic [NCH-1:0]             s_axis_imag_tvalid,
   input  logic [NCH-1:0]             s_axis_imag_tlast,
   output logic [NCH-1:0]             s_axis_imag_tready,
   output logic [2*SDATA_WIDTH-1:0]   m_axis_s2mm_tdata,
   output logic [2*SDATA_WIDTH/8-1:0] m_axis_s2mm_tkeep,
   output logic                       m_axis_s2mm_tvalid,
   output logic                       m_axis_s2mm_tlast,
   input  logic                       m_axis_s2mm_tready,
   output logic                       tlast_err
);

   localparam int SAMPLES = SDATA_WIDTH / SAMPLE_WIDTH;
   localparam int SUM_W   = SAMPLE_WIDTH + $clog2(NCH);
   localparam int KEEP_W  = 2*SDATA_WIDTH/8;

`ifdef AXIS_COMBINER_SAT_EN
   localparam logic signed [SUM_W-1:0] LANE_MAX =
      {{(SUM_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] LANE_MIN =
      {{(SUM_W-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};
`endif

   // Floor-shift a lane sum and bring it back to SAMPLE_WIDTH.
   function automatic logic signed [SAMPLE_WIDTH-1:0] scale_lane(
      input logic signed [SUM_W-1:0] s
   );
      logic signed [SUM_W-1:0] sh;
      sh = s >>> SHIFT;
`ifdef AXIS_COMBINER_SAT_EN
      if (sh > LANE_MAX)
         return LANE_MAX[SAMPLE_WIDTH-1:0];
      else if (sh < LANE_MIN)
         return LANE_MIN[SAMPLE_WIDTH-1:0];
      else
         return sh[SAMPLE_WIDTH-1:0];
`else
      return sh[SAMPLE_WIDTH-1:0];
`endif
   endfunction

   // Control state
   logic run_q;
   logic vld_p1;
   logic vld_p2;
   logic tlast_err_q;

   // Pipeline data
   logic signed [SUM_W-1:0]   sum_re_p1 [SAMPLES];
   logic signed [SUM_W-1:0]   sum_im_p1 [SAMPLES];
   logic                      last_p1;
   logic [2*SDATA_WIDTH-1:0]  data_p2;
   logic                      last_p2;

   // Combinational join / sum
   logic                      all_valid;
   logic                      rdy_p1;
   logic                      rdy_p2;
   logic                      fire;
   logic                      last_c;
   logic                      err_c;
   logic signed [SUM_W-1:0]   sum_re_c [SAMPLES];
   logic signed [SUM_W-1:0]   sum_im_c [SAMPLES];
   logic [2*SDATA_WIDTH-1:0]  data_c;

   // A stage accepts when empty or when its occupant leaves this cycle.
   assign rdy_p2 = !vld_p2 || m_axis_s2mm_tready;
   assign rdy_p1 = !vld_p1 || rdy_p2;

   always_comb begin
      all_valid = 1'b1;
      for (int k = 0; k < NCH; k++) begin
         if (ch_enable[k] && !(s_axis_real_tvalid[k] && s_axis_imag_tvalid[k]))
            all_valid = 1'b0;
      end
   end

   // run_q keeps every ready low while in reset and until the first edge
   // after release.
   assign fire = run_q && all_valid && (|ch_enable) && rdy_p1;
   assign s_axis_real_tready = {NCH{run_q && all_valid && rdy_p1}} & ch_enable;
   assign s_axis_imag_tready = {NCH{run_q && all_valid && rdy_p1}} & ch_enable;

   // Reference tlast comes from the lowest-index enabled real input; any
   // enabled real or imag tlast that disagrees flags an error.
   always_comb begin
      logic found;
      found  = 1'b0;
      last_c = 1'b0;
      err_c  = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         if (ch_enable[k] && !found) begin
            last_c = s_axis_real_tlast[k];
            found  = 1'b1;
         end
      end
      for (int k = 0; k < NCH; k++) begin
         if (ch_enable[k] &&
             ((s_axis_real_tlast[k] != last_c) || (s_axis_imag_tlast[k] != last_c)))
            err_c = 1'b1;
      end
   end

   always_comb begin
      logic signed [SAMPLE_WIDTH-1:0] smp;
      smp = '0;
      for (int l = 0; l < SAMPLES; l++) begin
         sum_re_c[l] = '0;
         sum_im_c[l] = '0;
      end
      for (int k = 0; k < NCH; k++) begin
         if (ch_enable[k]) begin
            for (int l = 0; l < SAMPLES; l++) begin
               smp = s_axis_real_tdata[k*SDATA_WIDTH + l*SAMPLE_WIDTH +: SAMPLE_WIDTH];
               sum_re_c[l] = sum_re_c[l] +
                  {{(SUM_W-SAMPLE_WIDTH){smp[SAMPLE_WIDTH-1]}}, smp};
               smp = s_axis_imag_tdata[k*SDATA_WIDTH + l*SAMPLE_WIDTH +: SAMPLE_WIDTH];
               sum_im_c[l] = sum_im_c[l] +
                  {{(SUM_W-SAMPLE_WIDTH){smp[SAMPLE_WIDTH-1]}}, smp};
            end
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         run_q       <= 1'b0;
         vld_p1      <= 1'b0;
         vld_p2      <= 1'b0;
         tlast_err_q <= 1'b0;
      end else begin
         run_q <= 1'b1;
         if (rdy_p1)
            vld_p1 <= fire;
         if (rdy_p2)
            vld_p2 <= vld_p1;
         if (fire && err_c)
            tlast_err_q <= 1'b1;
      end
   end

   // ---- stage 1: widened lane sums ----
   always_ff @(posedge clock) begin
      if (fire) begin
         sum_re_p1 <= sum_re_c;
         sum_im_p1 <= sum_im_c;
         last_p1   <= last_c;
      end
   end

   always_comb begin
      data_c = '0;
      for (int l = 0; l < SAMPLES; l++) begin
         data_c[l*SAMPLE_WIDTH +: SAMPLE_WIDTH]               = scale_lane(sum_re_p1[l]);
         data_c[SDATA_WIDTH + l*SAMPLE_WIDTH +: SAMPLE_WIDTH] = scale_lane(sum_im_p1[l]);
      end
   end

   // ---- stage 2: scaled, reduced output register ----
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         data_p2 <= '0;
         last_p2 <= 1'b0;
      end else if (rdy_p2 && vld_p1) begin
         data_p2 <= data_c;
         last_p2 <= last_p1;
      end
   end

   assign m_axis_s2mm_tdata  = data_p2;
   assign m_axis_s2mm_tlast  = last_p2;
   assign m_axis_s2mm_tvalid = vld_p2;
   assign m_axis_s2mm_tkeep  = {KEEP_W{vld_p2}};
   assign tlast_err          = tlast_err_q;

endmodule

// File: tb/tb_axis_complex_combiner.sv
// ---------------------------------------------------------------------------
// tb_axis_complex_combiner
//
// Two instances share every input: dut uses SHIFT=2, dut0 uses SHIFT=0. A
// behavioural model computes each expected output word from integer lane sums.
// ---------------------------------------------------------------------------
module tb_axis_complex_combiner;
   localparam int NCH = 4;
   localparam int SDW = 128;
   localparam int SW  = 16;
   localparam int SAMPLES = SDW / SW;
   localparam int KW  = 2*SDW/8;

   typedef struct {
      logic [NCH-1:0]     en;
      logic [NCH-1:0]     vm;
      logic [NCH-1:0]     rl;
      logic [NCH-1:0]     il;
      logic [NCH*SDW-1:0] rd;
      logic [NCH*SDW-1:0] id;
   } beat_t;

   typedef struct {
      logic [2*SDW-1:0] d;
      logic             l;
      logic [KW-1:0]    k;
   } out_t;

   logic clock = 1'b0;
   logic resetn = 1'b0;
   logic [NCH-1:0] ch_enable = '0;
   logic [NCH*SDW-1:0] rdata = '0, idata = '0;
   logic [NCH-1:0] rvalid = '0, ivalid = '0, rlast = '0, ilast = '0;
   logic [NCH-1:0] rready, iready, rready0, iready0;
   logic m_tready = 1'b1;
   logic [2*SDW-1:0] m_tdata, m_tdata0;
   logic [KW-1:0] m_tkeep, m_tkeep0;
   logic m_tvalid, m_tvalid0, m_tlast, m_tlast0, err, err0;

   int total = 0;
   int bad = 0;
   beat_t src_q[$];
   out_t exp_q[$], exp0_q[$], got_q[$], got0_q[$];
   int fires_total = 0;
   int outs_total = 0;
   int hold_bad, rdy_bad, max_occ, first_fire, last_fire;
   out_t mon_o, mon0_o;

   always #5 clock = ~clock;

   axis_complex_combiner #(.NCH(NCH), .SDATA_WIDTH(SDW), .SAMPLE_WIDTH(SW), .SHIFT(2)) dut (
      .clock(clock), .resetn(resetn), .ch_enable(ch_enable),
      .s_axis_real_tdata(rdata), .s_axis_real_tvalid(rvalid),
      .s_axis_real_tlast(rlast), .s_axis_real_tready(rready),
      .s_axis_imag_tdata(idata), .s_axis_imag_tvalid(ivalid),
      .s_axis_imag_tlast(ilast), .s_axis_imag_tready(iready),
      .m_axis_s2mm_tdata(m_tdata), .m_axis_s2mm_tkeep(m_tkeep),
      .m_axis_s2mm_tvalid(m_tvalid), .m_axis_s2mm_tlast(m_tlast),
      .m_axis_s2mm_tready(m_tready), .tlast_err(err));

   axis_complex_combiner #(.NCH(NCH), .SDATA_WIDTH(SDW), .SAMPLE_WIDTH(SW), .SHIFT(0)) dut0 (
      .clock(clock), .resetn(resetn), .ch_enable(ch_enable),
      .s_axis_real_tdata(rdata), .s_axis_real_tvalid(rvalid),
      .s_axis_real_tlast(rlast), .s_axis_real_tready(rready0),
      .s_axis_imag_tdata(idata), .s_axis_imag_tvalid(ivalid),
      .s_axis_imag_tlast(ilast), .s_axis_imag_tready(iready0),
      .m_axis_s2mm_tdata(m_tdata0), .m_axis_s2mm_tkeep(m_tkeep0),
      .m_axis_s2mm_tvalid(m_tvalid0), .m_axis_s2mm_tlast(m_tlast0),
      .m_axis_s2mm_tready(m_tready), .tlast_err(err0));

   // Output collector: records every accepted beat of both instances.
   always @(posedge clock) begin
      if (resetn && m_tready) begin
         if (m_tvalid) begin
            mon_o.d = m_tdata; mon_o.l = m_tlast; mon_o.k = m_tkeep;
            got_q.push_back(mon_o);
            outs_total++;
         end
         if (m_tvalid0) begin
            mon0_o.d = m_tdata0; mon0_o.l = m_tlast0; mon0_o.k = m_tkeep0;
            got0_q.push_back(mon0_o);
         end
      end
   end

   // Reference: integer lane sums over enabled channels, floor shift, reduce.
   function automatic logic [2*SDW-1:0] model_word(input beat_t b, input int sh);
      logic [2*SDW-1:0] w;
      logic signed [SW-1:0] v;
      logic [31:0] t;
      int sr, si;
      w = '0;
      for (int l = 0; l < SAMPLES; l++) begin
         sr = 0; si = 0;
         for (int k = 0; k < NCH; k++) begin
            if (b.en[k]) begin
               v = b.rd[k*SDW + l*SW +: SW]; sr += v;
               v = b.id[k*SDW + l*SW +: SW]; si += v;
            end
         end
         sr = sr >>> sh;
         si = si >>> sh;
`ifdef AXIS_COMBINER_SAT_EN
         if (sr > 32767) sr = 32767;
         if (sr < -32768) sr = -32768;
         if (si > 32767) si = 32767;
         if (si < -32768) si = -32768;
`endif
         t = sr; w[l*SW +: SW] = t[SW-1:0];
         t = si; w[SDW + l*SW +: SW] = t[SW-1:0];
      end
      return w;
   endfunction

   function automatic logic model_last(input beat_t b);
      for (int k = 0; k < NCH; k++)
         if (b.en[k]) return b.rl[k];
      return 1'b0;
   endfunction

   function automatic beat_t fill_beat(input logic [NCH-1:0] en, input logic [SW-1:0] rv,
                                       input logic [SW-1:0] iv, input logic t);
      beat_t b;
      b.en = en; b.vm = en; b.rl = {NCH{t}}; b.il = {NCH{t}};
      b.rd = '0; b.id = '0;
      for (int i = 0; i < NCH*SAMPLES; i++) begin
         b.rd[i*SW +: SW] = rv;
         b.id[i*SW +: SW] = iv;
      end
      return b;
   endfunction

   function automatic beat_t rand_beat(input logic [NCH-1:0] en, input logic t);
      beat_t b;
      b.en = en; b.vm = en;
      for (int i = 0; i < NCH*SDW/32; i++) begin
         b.rd[i*32 +: 32] = $urandom;
         b.id[i*32 +: 32] = $urandom;
      end
      for (int k = 0; k < NCH; k++) begin
         b.rl[k] = en[k] ? t : 1'($urandom_range(0, 1));
         b.il[k] = en[k] ? t : 1'($urandom_range(0, 1));
      end
      return b;
   endfunction

   task automatic drive(input beat_t b);
      ch_enable = b.en; rvalid = b.vm; ivalid = b.vm;
      rdata = b.rd; idata = b.id; rlast = b.rl; ilast = b.il;
   endtask

   task automatic clear_q();
      src_q.delete(); exp_q.delete(); exp0_q.delete();
      got_q.delete(); got0_q.delete();
      fires_total = 0; outs_total = 0;
   endtask

   // Offers the queued beats one by one and records handshake statistics.
   // mode 0: always ready, 1: random ready, 2: ready low for cycles [lo,hi).
   task automatic stream(input int mode, input int lo, input int hi);
      int cyc, occ;
      logic pv, pr, pl, f;
      logic [2*SDW-1:0] pd;
      beat_t b;
      out_t eo;
      cyc = 0; pv = 0; pr = 1; pl = 0; pd = '0;
      hold_bad = 0; rdy_bad = 0; max_occ = 0; first_fire = -1; last_fire = -1;
      while ((src_q.size() != 0 || fires_total != outs_total) && cyc < 2000) begin
         @(negedge clock);
         case (mode)
            0: m_tready = 1'b1;
            1: m_tready = 1'($urandom_range(0, 1));
            default: m_tready = !(cyc >= lo && cyc < hi);
         endcase
         if (src_q.size() != 0) begin
            b = src_q[0];
            drive(b);
         end else begin
            rvalid = '0; ivalid = '0;
         end
         #1;
         occ = fires_total - outs_total;
         if (occ > max_occ) max_occ = occ;
         if (pv && !pr && (m_tvalid !== 1'b1 || m_tdata !== pd || m_tlast !== pl)) hold_bad++;
         if (rready !== iready || rready0 !== iready0 || rready !== rready0) rdy_bad++;
         if (occ >= 2 && !m_tready && rready != '0) rdy_bad++;
         f = (src_q.size() != 0) && ((rready & b.en) != '0);
         if (src_q.size() != 0 && (rready & ~b.en) != '0) rdy_bad++;
         if (f) begin
            if ((rready & b.en) !== b.en) rdy_bad++;
            eo.d = model_word(b, 2); eo.l = model_last(b); eo.k = '1;
            exp_q.push_back(eo);
            eo.d = model_word(b, 0);
            exp0_q.push_back(eo);
            void'(src_q.pop_front());
            fires_total++;
            if (first_fire < 0) first_fire = cyc;
            last_fire = cyc;
         end
         pv = m_tvalid; pr = m_tready; pd = m_tdata; pl = m_tlast;
         cyc++;
      end
      if (cyc >= 2000) begin
         total++; bad++;
         $display("FAIL stream_timeout: fired=%0d out=%0d pending=%0d", fires_total, outs_total, src_q.size());
      end
   endtask

   task automatic test_reset();
      ch_enable = '1; rvalid = '1; ivalid = '1; m_tready = 1'b1;
      resetn = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
      total++; if (m_tdata !== '0) begin bad++; $display("FAIL rst_tdata: got %h want 0", m_tdata); end
      total++; if (m_tkeep !== '0 || m_tlast !== 1'b0) begin bad++; $display("FAIL rst_keep_last: got %h/%b want 0/0", m_tkeep, m_tlast); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err); end
      total++; if (rready !== '0 || iready !== '0) begin bad++; $display("FAIL rst_tready: got %b/%b want 0/0", rready, iready); end
      rvalid = '0; ivalid = '0;
      clear_q();
      @(negedge clock); resetn = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_latency();
      beat_t b;
      b = fill_beat('1, 16'h0123, 16'hFFF0, 1'b1);
      @(negedge clock); drive(b); m_tready = 1'b1; #1;
      total++; if (rready !== 4'hF) begin bad++; $display("FAIL lat_fire: tready got %b want 1111", rready); end
      @(negedge clock); rvalid = '0; ivalid = '0; #1;
      total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL lat_early: tvalid got %b want 0", m_tvalid); end
      @(negedge clock); #1;
      total++; if (m_tvalid !== 1'b1 || m_tdata !== model_word(b, 2) || m_tkeep !== '1)
         begin bad++; $display("FAIL lat_out: tvalid=%b data=%h want 1 %h", m_tvalid, m_tdata, model_word(b, 2)); end
      repeat (3) @(negedge clock);
      clear_q();
   endtask

   task automatic test_constant_stream();
      logic [2*SDW-1:0] cw;
      for (int l = 0; l < SAMPLES; l++) begin
         cw[l*SW +: SW] = 16'h1000;
         cw[SDW + l*SW +: SW] = 16'hF000;
      end
      for (int i = 0; i < 64; i++) src_q.push_back(fill_beat('1, 16'h1000, 16'hF000, 1'(i == 63)));
      stream(0, 0, 0);
      total++; if (last_fire - first_fire != 63) begin bad++; $display("FAIL const_rate: span got %0d want 63", last_fire - first_fire); end
      total++; if (hold_bad != 0 || rdy_bad != 0) begin bad++; $display("FAIL const_hs: hold=%0d rdy=%0d want 0", hold_bad, rdy_bad); end
      total++; if (got_q.size() != 64 || got0_q.size() != 64) begin bad++; $display("FAIL const_count: got %0d/%0d want 64", got_q.size(), got0_q.size()); end
      for (int i = 0; i < got_q.size() && i < 64; i++) begin
         total++;
         if (got_q[i].d !== cw || got_q[i].l !== 1'(i == 63) || got_q[i].k !== '1)
            begin bad++; $display("FAIL const_beat%0d: got %h last %b want %h", i, got_q[i].d, got_q[i].l, cw); end
      end
      for (int i = 0; i < got0_q.size() && i < exp0_q.size(); i++) begin
         total++;
         if (got0_q[i].d !== exp0_q[i].d) begin bad++; $display("FAIL const0_beat%0d: got %h want %h", i, got0_q[i].d, exp0_q[i].d); end
      end
      clear_q();
   endtask

   task automatic test_partial_mask();
      beat_t b;
      int leak;
      for (int i = 0; i < 6; i++) begin
         b = fill_beat(4'b0101, 16'd100, 16'd100, 1'b0);
         for (int l = 0; l < SAMPLES; l++) begin
            b.rd[2*SDW + l*SW +: SW] = 16'd200;
            b.id[2*SDW + l*SW +: SW] = 16'd200;
            b.rd[1*SDW + l*SW +: SW] = 16'($urandom);
            b.rd[3*SDW + l*SW +: SW] = 16'($urandom);
         end
         src_q.push_back(b);
      end
      stream(1, 0, 0);
      total++; if (rdy_bad != 0 || hold_bad != 0) begin bad++; $display("FAIL part_hs: rdy=%0d hold=%0d want 0", rdy_bad, hold_bad); end
      total++; if (got_q.size() != 6 || got0_q.size() != 6) begin bad++; $display("FAIL part_count: got %0d want 6", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < got0_q.size(); i++) begin
         total++;
         if (got0_q[i].d !== {16{16'd300}} || got_q[i].d !== {16{16'd75}})
            begin bad++; $display("FAIL part_beat%0d: got %h / %h want lanes 300 / 75", i, got0_q[i].d, got_q[i].d); end
      end
      clear_q();
      // One enabled channel never valid: the other enabled channel is held.
      leak = 0;
      ch_enable = 4'b0011; rvalid = 4'b0001; ivalid = 4'b0001; m_tready = 1'b1;
      repeat (6) begin
         @(negedge clock); #1;
         if (rready != '0 || iready != '0) leak++;
      end
      total++; if (leak != 0 || m_tvalid !== 1'b0) begin bad++; $display("FAIL part_hold: leak=%0d tvalid=%b want 0/0", leak, m_tvalid); end
      rvalid = '0; ivalid = '0;
      @(negedge clock);
   endtask

   task automatic test_overflow();
      logic [SW-1:0] re_want, im_want;
`ifdef AXIS_COMBINER_SAT_EN
      re_want = 16'h7FFF; im_want = 16'h8000;
`else
      re_want = 16'hFFFC; im_want = 16'h0000;
`endif
      for (int i = 0; i < 3; i++) src_q.push_back(fill_beat('1, 16'h7FFF, 16'h8000, 1'b0));
      stream(0, 0, 0);
      total++; if (got0_q.size() != 3 || got_q.size() != 3) begin bad++; $display("FAIL ovf_count: got %0d want 3", got0_q.size()); end
      for (int i = 0; i < got0_q.size() && i < got_q.size(); i++) begin
         total++;
         if (got0_q[i].d !== {{8{im_want}}, {8{re_want}}} || got_q[i].d !== {{8{16'h8000}}, {8{16'h7FFF}}})
            begin bad++; $display("FAIL ovf_beat%0d: got %h / %h want re %h im %h", i, got0_q[i].d, got_q[i].d, re_want, im_want); end
      end
      clear_q();
   endtask

   task automatic test_backpressure();
      int nlast;
      for (int i = 0; i < 8; i++) src_q.push_back(rand_beat('1, 1'(i == 7)));
      stream(2, 3, 8);
      total++; if (max_occ != 2) begin bad++; $display("FAIL bp_occupancy: got %0d want 2", max_occ); end
      total++; if (hold_bad != 0 || rdy_bad != 0) begin bad++; $display("FAIL bp_hs: hold=%0d rdy=%0d want 0", hold_bad, rdy_bad); end
      total++; if (got_q.size() != 8 || got0_q.size() != 8) begin bad++; $display("FAIL bp_count: got %0d want 8", got_q.size()); end
      nlast = 0;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         if (got_q[i].l) nlast++;
         total++;
         if (got_q[i].d !== exp_q[i].d || got_q[i].l !== exp_q[i].l || got0_q[i].d !== exp0_q[i].d)
            begin bad++; $display("FAIL bp_beat%0d: got %h last %b want %h last %b", i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l); end
      end
      total++; if (nlast != 1 || got_q.size() != 8 || got_q[7].l !== 1'b1) begin bad++; $display("FAIL bp_tlast: count %0d want 1 on beat 8", nlast); end
      clear_q();
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++)
         src_q.push_back(rand_beat(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1))));
      stream(1, 0, 0);
      total++; if (hold_bad != 0 || rdy_bad != 0 || max_occ > 2) begin bad++; $display("FAIL rnd_hs: hold=%0d rdy=%0d occ=%0d", hold_bad, rdy_bad, max_occ); end
      total++; if (got_q.size() != 40 || got0_q.size() != 40) begin bad++; $display("FAIL rnd_count: got %0d/%0d want 40", got_q.size(), got0_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size() && i < got0_q.size(); i++) begin
         total++;
         if (got_q[i].d !== exp_q[i].d || got_q[i].l !== exp_q[i].l || got0_q[i].d !== exp0_q[i].d || got_q[i].k !== '1)
            begin bad++; $display("FAIL rnd_beat%0d: got %h last %b want %h last %b", i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l); end
      end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rnd_err: got %b want 0", err); end
      clear_q();
   endtask

   task automatic test_tlast_err();
      beat_t b;
      src_q.push_back(rand_beat('1, 1'b0));
      src_q.push_back(rand_beat('1, 1'b0));
      stream(0, 0, 0);
      total++; if (err !== 1'b0) begin bad++; $display("FAIL terr_before: got %b want 0", err); end
      b = rand_beat('1, 1'b0);
      b.rl = 4'b0100;
      src_q.push_back(b);
      stream(0, 0, 0);
      total++; if (err !== 1'b1 || err0 !== 1'b1) begin bad++; $display("FAIL terr_set: got %b/%b want 1", err, err0); end
      src_q.push_back(rand_beat('1, 1'b0));
      src_q.push_back(rand_beat('1, 1'b1));
      stream(0, 0, 0);
      total++; if (err !== 1'b1) begin bad++; $display("FAIL terr_sticky: got %b want 1", err); end
      total++; if (got_q.size() != 5) begin bad++; $display("FAIL terr_count: got %0d want 5", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         total++;
         if (got_q[i].d !== exp_q[i].d || got_q[i].l !== exp_q[i].l)
            begin bad++; $display("FAIL terr_beat%0d: got %h last %b want %h last %b", i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l); end
      end
      clear_q();
   endtask

   task automatic test_reset_midflight();
      beat_t b;
      m_tready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         b = rand_beat('1, 1'b0);
         @(negedge clock); drive(b);
      end
      @(negedge clock); rvalid = '0; ivalid = '0; #1;
      total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL mid_inflight: tvalid got %b want 1", m_tvalid); end
      @(posedge clock); #3;
      resetn = 1'b0; #1;
      total++; if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tkeep !== '0 || m_tlast !== 1'b0)
         begin bad++; $display("FAIL mid_async: tvalid=%b data=%h keep=%h want all 0", m_tvalid, m_tdata, m_tkeep); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL mid_err_clear: got %b want 0", err); end
      clear_q();
      @(negedge clock); resetn = 1'b1; m_tready = 1'b1;
      repeat (6) @(negedge clock);
      #1;
      total++; if (got_q.size() != 0 || m_tvalid !== 1'b0) begin bad++; $display("FAIL mid_stale: beats %0d tvalid %b want 0", got_q.size(), m_tvalid); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_constant_stream();
      test_partial_mask();
      test_overflow();
      test_backpressure();
      test_random();
      test_tlast_err();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
